ahblite_slave_mux: RTL and testbench
====================================

# ahblite_slave_mux

AHB-Lite data-phase multiplexer with integrated default slave, sitting directly downstream of the address decoder on the single-master bus. It captures the decoder's six one-hot port selects during each accepted address phase. During the following data phase it routes the selected slave's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 master. Transfers that hit no enabled port receive a standard two-cycle ERROR response from the default slave.

## Interface
Parameters:
- PORT_EN, 6'b011111: per-port enable, bit i = port i (RAMCODE, RAMDATA, LCD, UART, Camera, Buzzer); a disabled port is treated as unselected.

Ports (one clock; reset is asynchronous and active-low):
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HTRANS  in  2  master transfer type (bit 1 = NONSEQ/SEQ)
- P0_HSEL..P5_HSEL  in  1 each  address-phase selects from decoder
- P0_HREADYOUT..P5_HREADYOUT  in  1 each  slave ready
- P0_HRESP..P5_HRESP  in  1 each  slave response (0 OKAY, 1 ERROR)
- P0_HRDATA..P5_HRDATA  in  32 each  slave read data
- HREADY  out  1  global ready to master and all slaves
- HRESP  out  1  global response to master
- HRDATA  out  32  global read data to master

## Operation
- Address-phase capture: on a rising HCLK edge with HREADY=1, sel_q[5:0] <= {P5_HSEL..P0_HSEL} & PORT_EN. With HREADY=0, sel_q holds.
- Priority: if more than one sel bit is set, the lowest index wins. The decoder map is exclusive, so this is a robustness rule only.
- Data-phase routing: if sel_q has any bit set, winning index i drives HRDATA=Pi_HRDATA, HREADY=Pi_HREADYOUT, HRESP=Pi_HRESP, all combinational from sel_q.
- Default-slave trigger: an accepted address phase (HREADY=1) with no enabled HSEL and HTRANS[1]=1 starts the default slave.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0, HRDATA=0. Trigger -> ERR1, otherwise stay.
  - ERR1: HREADY=0, HRESP=1, HRDATA=0. Always -> ERR2.
  - ERR2: HREADY=1, HRESP=1, HRDATA=0. Trigger -> ERR1, otherwise -> IDLE.
- The FSM only drives the outputs when sel_q==0. A trigger and a valid sel are mutually exclusive by construction.
- Unmapped IDLE/BUSY transfer (HTRANS[1]=0, no HSEL): zero-wait OKAY (HREADY=1, HRESP=0, HRDATA=0).
- Slave wait states: while the selected Pi_HREADYOUT=0, HREADY=0 and sel_q holds. The next address phase is not captured until Pi_HREADYOUT=1.
- Slave ERROR: passed through unmodified. The two-cycle protocol is the slave's responsibility.
- Master dropping HTRANS to IDLE during ERR1: ignored, because HREADY=0 blocks capture.

## Timing
- Reset (HRESETn=0, asynchronous): sel_q=0, FSM=IDLE. Outputs HREADY=1, HRESP=0, HRDATA=0.
- Reset asserted mid-transfer, including mid-ERR1 or a slave wait: outputs return to the reset values immediately, with no clock required.
- Select latency: exactly 1 HCLK from address phase to routed data phase.
- Output paths: no registered outputs. All outputs are combinational from sel_q, FSM state, and slave inputs.
- Error response: exactly 2 data-phase cycles (ERR1, ERR2).
- Back-to-back unmapped NONSEQ transfers: ERR1, ERR2, ERR1, ERR2, ... with no IDLE gap.

## Structure
- Shared package ahblite_pkg:
  - HTRANS encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11)
  - HRESP_OKAY / HRESP_ERROR
  - NPORT=6
  - default-slave state enum
- Sub-module ahblite_default_slave:
  - contains the IDLE/ERR1/ERR2 FSM
  - inputs: HCLK, HRESETn, HREADY, HTRANS, any_sel
  - outputs: ds_hreadyout, ds_hresp
- Top level: sel_q register, priority encoder, output mux.

## Test plan
- Reset: hold HRESETn=0 with random slave inputs -> HREADY=1, HRESP=0, HRDATA=0. Release HRESETn -> outputs unchanged until the first capture.
- RAMDATA read: P1_HSEL=1, HTRANS=NONSEQ at cycle 0; P1_HRDATA=32'hDEADBEEF, P1_HREADYOUT=1 at cycle 1 -> HRDATA=32'hDEADBEEF, HREADY=1, HRESP=0 at cycle 1.
- Wait-state hold:
  - Stimulus: P3 selected, P3_HREADYOUT=0 for 3 cycles, while P0_HSEL=1 is presented during the stall.
  - Required: HREADY=0 for 3 cycles and sel_q stays on port 3. Port 0 is captured only on the cycle P3_HREADYOUT=1.
- Unmapped NONSEQ (e.g. HADDR 0x60000000, all HSEL=0) -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then IDLE OKAY.
- Disabled port and back-to-back errors:
  - Stimulus: PORT_EN=6'b011111, P5_HSEL=1 with NONSEQ on two consecutive accepted phases.
  - Required: ERR1, ERR2, ERR1, ERR2. P5_HRDATA never appears on HRDATA.
- Reset mid-ERR1: assert HRESETn=0 while HREADY=0/HRESP=1 -> immediately HREADY=1, HRESP=0. After release, FSM=IDLE.

Source files
------------

// File: rtl/ahblite_pkg.sv
// ----------------------------------------------------------------------------
// ahblite_pkg
// Shared AHB-Lite definitions for the single-master bus fabric: transfer
// type encodings, response encodings, slave port count and the default
// slave state type.
// ----------------------------------------------------------------------------
package ahblite_pkg;

    localparam int DATA_W = 32;
    localparam int NPORT  = 6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // A transfer that actually moves data (NONSEQ or SEQ).
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage : ahblite_pkg

// File: rtl/ahblite_default_slave.sv
// ----------------------------------------------------------------------------
// ahblite_default_slave
// Answers transfers that hit no enabled slave port with the two-cycle
// AHB-Lite ERROR response. IDLE/BUSY transfers to unmapped space get a
// zero-wait OKAY (the FSM simply stays in IDLE).
//
// Ports:
//   HCLK          bus clock
//   HRESETn       asynchronous active-low reset
//   HREADY        global HREADY (qualifies the address phase)
//   HTRANS        master transfer type of the current address phase
//   any_sel       some enabled port is selected in the current address phase
//   ds_hreadyout  default slave HREADYOUT (registered with the state)
//   ds_hresp      default slave HRESP     (registered with the state)
// ----------------------------------------------------------------------------
module ahblite_default_slave
    import ahblite_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       any_sel,
    output logic       ds_hreadyout,
    output logic       ds_hresp
);

    ds_state_t state;
    logic      trigger;

    // Accepted address phase of a real transfer that no enabled port claims.
    assign trigger = HREADY && !any_sel && is_active_trans(HTRANS);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= DS_IDLE;
            ds_hreadyout <= 1'b1;
            ds_hresp     <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (trigger) begin
                        state        <= DS_ERR1;
                        ds_hreadyout <= 1'b0;
                        ds_hresp     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state        <= DS_ERR2;
                    ds_hreadyout <= 1'b1;
                    ds_hresp     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // ERR2 completes the transfer, so the next address phase
                    // may itself be unmapped: chain straight into ERR1.
                    if (trigger) begin
                        state        <= DS_ERR1;
                        ds_hreadyout <= 1'b0;
                        ds_hresp     <= HRESP_ERROR;
                    end else begin
                        state        <= DS_IDLE;
                        ds_hreadyout <= 1'b1;
                        ds_hresp     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state        <= DS_IDLE;
                    ds_hreadyout <= 1'b1;
                    ds_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule : ahblite_default_slave

// File: rtl/ahblite_slave_mux.sv
// ----------------------------------------------------------------------------
// ahblite_slave_mux
// AHB-Lite data-phase multiplexer for six slave ports plus a default slave.
// Port selects are captured during each accepted address phase; during the
// following data phase the selected slave's HRDATA/HREADYOUT/HRESP are routed
// back to the master. Unclaimed transfers are handled by the default slave.
//
// Parameters:
//   PORT_EN   per-port enable, bit i = port i
//             (RAMCODE, RAMDATA, LCD, UART, Camera, Buzzer)
//
// Ports:
//   HCLK, HRESETn                 clock, asynchronous active-low reset
//   HTRANS                        master transfer type
//   Pn_HSEL                       address-phase selects from the decoder
//   Pn_HREADYOUT, Pn_HRESP        slave ready / response
//   Pn_HRDATA                     slave read data
//   HREADY, HRESP, HRDATA         global ready, response, read data
// ----------------------------------------------------------------------------
module ahblite_slave_mux
    import ahblite_pkg::*;
#(
    parameter logic [NPORT-1:0] PORT_EN = 6'b011111
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [1:0]        HTRANS,
    input  logic              P0_HSEL,
    input  logic              P1_HSEL,
    input  logic              P2_HSEL,
    input  logic              P3_HSEL,
    input  logic              P4_HSEL,
    input  logic              P5_HSEL,
    input  logic              P0_HREADYOUT,
    input  logic              P1_HREADYOUT,
    input  logic              P2_HREADYOUT,
    input  logic              P3_HREADYOUT,
    input  logic              P4_HREADYOUT,
    input  logic              P5_HREADYOUT,
    input  logic              P0_HRESP,
    input  logic              P1_HRESP,
    input  logic              P2_HRESP,
    input  logic              P3_HRESP,
    input  logic              P4_HRESP,
    input  logic              P5_HRESP,
    input  logic [DATA_W-1:0] P0_HRDATA,
    input  logic [DATA_W-1:0] P1_HRDATA,
    input  logic [DATA_W-1:0] P2_HRDATA,
    input  logic [DATA_W-1:0] P3_HRDATA,
    input  logic [DATA_W-1:0] P4_HRDATA,
    input  logic [DATA_W-1:0] P5_HRDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    logic [NPORT-1:0]  hsel_en;
    logic              any_sel;
    logic [NPORT-1:0]  sel_q;
    logic [NPORT-1:0]  slv_ready;
    logic [NPORT-1:0]  slv_resp;
    logic [DATA_W-1:0] slv_rdata [NPORT];
    logic [2:0]        win_idx;
    logic              win_vld;
    logic              ds_hreadyout;
    logic              ds_hresp;

    // Disabled ports are masked here so they look unselected everywhere,
    // including to the default slave trigger.
    assign hsel_en = {P5_HSEL, P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
    assign any_sel = |hsel_en;

    assign slv_ready = {P5_HREADYOUT, P4_HREADYOUT, P3_HREADYOUT,
                        P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign slv_resp  = {P5_HRESP, P4_HRESP, P3_HRESP,
                        P2_HRESP, P1_HRESP, P0_HRESP};

    assign slv_rdata[0] = P0_HRDATA;
    assign slv_rdata[1] = P1_HRDATA;
    assign slv_rdata[2] = P2_HRDATA;
    assign slv_rdata[3] = P3_HRDATA;
    assign slv_rdata[4] = P4_HRDATA;
    assign slv_rdata[5] = P5_HRDATA;

    // Address phase -> data phase boundary: selects held through wait states.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= '0;
        end else if (HREADY) begin
            sel_q <= hsel_en;
        end
    end

    // Lowest index wins; scanning downward lets the lowest set bit land last.
    always_comb begin
        win_idx = 3'd0;
        win_vld = 1'b0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (sel_q[i]) begin
                win_idx = 3'(i);
                win_vld = 1'b1;
            end
        end
    end

    ahblite_default_slave u_default_slave (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HREADY       (HREADY),
        .HTRANS       (HTRANS),
        .any_sel      (any_sel),
        .ds_hreadyout (ds_hreadyout),
        .ds_hresp     (ds_hresp)
    );

    // HREADY does not depend on the HSEL inputs, so feeding it back into the
    // capture enable and the default slave forms no combinational loop.
    always_comb begin
        HREADY = ds_hreadyout;
        HRESP  = ds_hresp;
        HRDATA = '0;
        if (win_vld) begin
            HREADY = slv_ready[win_idx];
            HRESP  = slv_resp[win_idx];
            HRDATA = slv_rdata[win_idx];
        end
    end

endmodule : ahblite_slave_mux

// File: tb/tb_ahblite_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_ahblite_slave_mux
// Directed scoreboard bench for ahblite_slave_mux with default PORT_EN.
// Each bus cycle the bench drives the address-phase inputs, queues the
// outputs the master must see in that cycle, and pops/compares them before
// the next rising edge.
// ----------------------------------------------------------------------------
module tb_ahblite_slave_mux;

    typedef struct {
        string       tag;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
    } exp_t;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  HTRANS;
    logic [5:0]  hsel;
    logic [5:0]  rdy;
    logic [5:0]  rsp;
    logic [31:0] rdata [6];
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ahblite_slave_mux dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HTRANS       (HTRANS),
        .P0_HSEL      (hsel[0]),
        .P1_HSEL      (hsel[1]),
        .P2_HSEL      (hsel[2]),
        .P3_HSEL      (hsel[3]),
        .P4_HSEL      (hsel[4]),
        .P5_HSEL      (hsel[5]),
        .P0_HREADYOUT (rdy[0]),
        .P1_HREADYOUT (rdy[1]),
        .P2_HREADYOUT (rdy[2]),
        .P3_HREADYOUT (rdy[3]),
        .P4_HREADYOUT (rdy[4]),
        .P5_HREADYOUT (rdy[5]),
        .P0_HRESP     (rsp[0]),
        .P1_HRESP     (rsp[1]),
        .P2_HRESP     (rsp[2]),
        .P3_HRESP     (rsp[3]),
        .P4_HRESP     (rsp[4]),
        .P5_HRESP     (rsp[5]),
        .P0_HRDATA    (rdata[0]),
        .P1_HRDATA    (rdata[1]),
        .P2_HRDATA    (rdata[2]),
        .P3_HRDATA    (rdata[3]),
        .P4_HRDATA    (rdata[4]),
        .P5_HRDATA    (rdata[5]),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .HRDATA       (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue the expectation, then pop it against the live outputs.
    task automatic expect_now(input string tag, input logic e_rdy, input logic e_resp,
                              input logic [31:0] e_data);
        exp_t e;
        e.tag  = tag;
        e.rdy  = e_rdy;
        e.resp = e_resp;
        e.data = e_data;
        exp_q.push_back(e);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_hready"}, {31'd0, HREADY}, {31'd0, e.rdy});
            check({e.tag, "_hresp"},  {31'd0, HRESP},  {31'd0, e.resp});
            check({e.tag, "_hrdata"}, HRDATA, e.data);
        end
    endtask

    // One bus cycle: address phase driven at the falling edge, data-phase
    // outputs compared shortly after, returns just after the next rising edge.
    task automatic cyc(input string tag, input logic [5:0] sel, input logic [1:0] trans,
                       input logic e_rdy, input logic e_resp, input logic [31:0] e_data);
        @(negedge HCLK);
        hsel   = sel;
        HTRANS = trans;
        #2;
        expect_now(tag, e_rdy, e_resp, e_data);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HTRANS  = 2'b00;
        hsel    = 6'b0;
        rdy     = 6'h3f;
        rsp     = 6'b0;
        for (int i = 0; i < 6; i++) rdata[i] = $urandom;

        // Reset held with random slave activity: outputs stay at reset values.
        for (int k = 0; k < 3; k++) begin
            rdy = 6'($urandom);
            rsp = 6'($urandom);
            for (int i = 0; i < 6; i++) rdata[i] = $urandom;
            cyc("rst", 6'($urandom), 2'b10, 1'b1, 1'b0, 32'h0);
        end
        rdy = 6'h3f;
        rsp = 6'b0;
        HRESETn = 1'b1;
        cyc("rel0", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        cyc("rel1", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);

        // RAMDATA read.
        rdata[1] = 32'hDEADBEEF;
        cyc("p1_addr", 6'b000010, 2'b10, 1'b1, 1'b0, 32'h0);
        cyc("p1_data", 6'b000000, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF);
        cyc("p1_after", 6'b000000, 2'b00, 1'b1, 1'b0, 32'h0);

        // Wait-state hold on port 3 while port 0 is presented.
        rdata[3] = 32'h33333333;
        rdata[0] = 32'h00000A0A;
        cyc("p3_addr", 6'b001000, 2'b10, 1'b1, 1'b0, 32'h0);
        rdy[3] = 1'b0;
        cyc("p3_wait0", 6'b000001, 2'b10, 1'b0, 1'b0, 32'h33333333);
        cyc("p3_wait1", 6'b000001, 2'b10, 1'b0, 1'b0, 32'h33333333);
        cyc("p3_wait2", 6'b000001, 2'b10, 1'b0, 1'b0, 32'h33333333);
        rdy[3] = 1'b1;
        cyc("p3_done", 6'b000001, 2'b10, 1'b1, 1'b0, 32'h33333333);
        cyc("p0_data", 6'b000000, 2'b00, 1'b1, 1'b0, 32'h00000A0A);

        // Unmapped NONSEQ: two-cycle error then OKAY.
        cyc("um_addr", 6'b0, 2'b10, 1'b1, 1'b0, 32'h0);
        cyc("um_err1", 6'b0, 2'b00, 1'b0, 1'b1, 32'h0);
        cyc("um_err2", 6'b0, 2'b00, 1'b1, 1'b1, 32'h0);
        cyc("um_idle", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);

        // Unmapped BUSY: zero-wait OKAY.
        cyc("busy_addr", 6'b0, 2'b01, 1'b1, 1'b0, 32'h0);
        cyc("busy_data", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);

        // Disabled port 5, back-to-back; second phase presented during ERR1
        // is ignored, the one presented in ERR2 is accepted.
        rdata[5] = 32'h55555555;
        cyc("p5_addr", 6'b100000, 2'b10, 1'b1, 1'b0, 32'h0);
        cyc("p5_err1a", 6'b100000, 2'b10, 1'b0, 1'b1, 32'h0);
        cyc("p5_err2a", 6'b100000, 2'b10, 1'b1, 1'b1, 32'h0);
        cyc("p5_err1b", 6'b000000, 2'b00, 1'b0, 1'b1, 32'h0);
        cyc("p5_err2b", 6'b000000, 2'b00, 1'b1, 1'b1, 32'h0);
        cyc("p5_idle", 6'b000000, 2'b00, 1'b1, 1'b0, 32'h0);

        // Multiple selects: lowest index wins.
        rdata[2] = 32'h22222222;
        cyc("pri_addr", 6'b000110, 2'b10, 1'b1, 1'b0, 32'h0);
        cyc("pri_data", 6'b000000, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF);

        // Slave ERROR passed through unmodified.
        cyc("p2_addr", 6'b000100, 2'b10, 1'b1, 1'b0, 32'h0);
        rdy[2] = 1'b0;
        rsp[2] = 1'b1;
        cyc("p2_err1", 6'b000000, 2'b00, 1'b0, 1'b1, 32'h22222222);
        rdy[2] = 1'b1;
        cyc("p2_err2", 6'b000000, 2'b00, 1'b1, 1'b1, 32'h22222222);
        rsp[2] = 1'b0;
        cyc("p2_idle", 6'b000000, 2'b00, 1'b1, 1'b0, 32'h0);

        // Reset mid-ERR1 takes effect without a clock edge.
        cyc("r_addr", 6'b0, 2'b10, 1'b1, 1'b0, 32'h0);
        HTRANS = 2'b00;
        #1;
        expect_now("r_err1", 1'b0, 1'b1, 32'h0);
        HRESETn = 1'b0;
        #1;
        expect_now("r_async", 1'b1, 1'b0, 32'h0);
        @(posedge HCLK);
        #1;
        cyc("r_hold", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        HRESETn = 1'b1;
        cyc("r_after", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        cyc("r_um", 6'b0, 2'b10, 1'b1, 1'b0, 32'h0);
        cyc("r_um_err1", 6'b0, 2'b00, 1'b0, 1'b1, 32'h0);
        cyc("r_um_err2", 6'b0, 2'b00, 1'b1, 1'b1, 32'h0);

        // Reset during a slave wait state.
        cyc("w_addr", 6'b010000, 2'b10, 1'b1, 1'b0, 32'h0);
        rdy[4]   = 1'b0;
        rdata[4] = 32'h44444444;
        #1;
        expect_now("w_wait", 1'b0, 1'b0, 32'h44444444);
        HRESETn = 1'b0;
        #1;
        expect_now("w_async", 1'b1, 1'b0, 32'h0);
        rdy[4] = 1'b1;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cyc("w_after", 6'b0, 2'b00, 1'b1, 1'b0, 32'h0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ahblite_slave_mux
